// File: rtl/cr_kme_word_unpacker.sv
// Read-side consumer of the KME staging FIFO: pops one wide word per handshake and
// serializes it, least significant slice first, onto a valid/ready beat stream.
module cr_kme_word_unpacker #(
    parameter int unsigned IN_WIDTH  = 96,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ack,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [1:0]           out_idx,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    input  logic                 stall_clr
);

    localparam int unsigned BEATS = IN_WIDTH / OUT_WIDTH;
    localparam logic [1:0]  LAST_IDX = 2'(BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // The slice index is carried on a 2-bit port, so at most four beats per word.
    if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
        $error("cr_kme_word_unpacker: IN_WIDTH must be an exact multiple of OUT_WIDTH");
    end
    if ((BEATS < 1) || (BEATS > 4)) begin : g_beats_check
        $error("cr_kme_word_unpacker: IN_WIDTH/OUT_WIDTH must be in 1..4");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IN_WIDTH-1:0]    hold_q, hold_d;
    logic [1:0]             idx_q, idx_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   beat;
    logic                   word_done;

    function automatic logic [OUT_WIDTH-1:0] slice_of(input logic [IN_WIDTH-1:0] w,
                                                      input logic [1:0] i);
        return OUT_WIDTH'(w >> (OUT_WIDTH * 32'(i)));
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            idx_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, pop strobe and beat sequencing
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        beat      = valid_q & out_ready;
        word_done = beat & (idx_q == LAST_IDX);
        in_ack    = ~rst & in_valid & ~flush & ((state_q == ST_IDLE) | word_done);

        if (flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            idx_d   = 2'd0;
            last_d  = 1'b0;
        end else if (in_ack) begin
            // Covers both the idle pop and the zero-bubble reload on the final beat.
            state_d = ST_SEND;
            hold_d  = in_data;
            idx_d   = 2'd0;
            data_d  = slice_of(in_data, 2'd0);
            valid_d = 1'b1;
            last_d  = (LAST_IDX == 2'd0);
        end else begin
            case (state_q)
                ST_SEND: begin
                    if (word_done) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        idx_d   = 2'd0;
                        last_d  = 1'b0;
                    end else if (beat) begin
                        idx_d  = idx_q + 2'd1;
                        data_d = slice_of(hold_q, idx_q + 2'd1);
                        last_d = ((idx_q + 2'd1) == LAST_IDX);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles where a beat is offered but not taken
    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_idx   = idx_q;
    assign stall_cnt = cnt_q;

endmodule
